// File: rtl/pll_reset_seq.sv
// PLL reset/lock sequencer: pulses pll_rst, waits for a stable lock, then releases sys_rst.
// Optional PLL_RESET_SEQ_LOSS_CNT_EN adds lock_loss_cnt, a saturating count of lock losses seen in RUN.
module pll_reset_seq #(
   parameter int unsigned RST_PULSE_CYCLES    = 50,
   parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
   parameter int unsigned MAX_RETRIES         = 3,
   parameter int unsigned CNT_W               = 17
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic       sys_rst,
   output logic       ready,
   output logic       fail,
`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
   output logic [7:0] lock_loss_cnt,
`endif
   output logic [1:0] retry_count
);

   localparam logic [2:0] S_RESET     = 3'd0;
   localparam logic [2:0] S_WAIT_LOCK = 3'd1;
   localparam logic [2:0] S_STABLE    = 3'd2;
   localparam logic [2:0] S_RUN       = 3'd3;
   localparam logic [2:0] S_FAIL      = 3'd4;

   localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRIES);

   logic             r_sync1;
   logic             r_sync2;
   logic [2:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_retry;
   logic             r_pllRst;
   logic             r_sysRst;
   logic             r_ready;
   logic             r_fail;

   logic [2:0]       w_nextState;
   logic [CNT_W-1:0] w_nextCnt;
   logic [1:0]       w_nextRetry;

   // pll_locked is asynchronous to refclk; only the second flop feeds decisions
   always_ff @(posedge refclk) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= pll_locked;
         r_sync2 <= r_sync1;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_nextCnt   = r_cnt;
      w_nextRetry = r_retry;
      case (r_state)
         S_RESET: begin
            if (r_cnt == PULSE_LAST) begin
               w_nextState = S_WAIT_LOCK;
               w_nextCnt   = '0;
            end else begin
               w_nextCnt = r_cnt + 1'b1;
            end
         end
         S_WAIT_LOCK: begin
            // Lock takes priority over a timeout landing on the same cycle
            if (r_sync2) begin
               w_nextState = S_STABLE;
               w_nextCnt   = '0;
            end else if (r_cnt == TIMEOUT_LAST) begin
               w_nextCnt = '0;
               if (r_retry < RETRY_MAX) begin
                  w_nextRetry = r_retry + 1'b1;
                  w_nextState = S_RESET;
               end else begin
                  w_nextState = S_FAIL;
               end
            end else begin
               w_nextCnt = r_cnt + 1'b1;
            end
         end
         S_STABLE: begin
            if (!r_sync2) begin
               w_nextState = S_WAIT_LOCK;
               w_nextCnt   = '0;
            end else if (r_cnt == STABLE_LAST) begin
               w_nextState = S_RUN;
               w_nextCnt   = '0;
               w_nextRetry = 2'd0;
            end else begin
               w_nextCnt = r_cnt + 1'b1;
            end
         end
         S_RUN: begin
            if (!r_sync2) begin
               w_nextState = S_RESET;
               w_nextCnt   = '0;
            end
         end
         S_FAIL: begin
            w_nextState = S_FAIL;
         end
         default: begin
            w_nextState = S_RESET;
            w_nextCnt   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they change on the same edge as the state
   always_ff @(posedge refclk) begin
      if (rst) begin
         r_state  <= S_RESET;
         r_cnt    <= '0;
         r_retry  <= 2'd0;
         r_pllRst <= 1'b1;
         r_sysRst <= 1'b1;
         r_ready  <= 1'b0;
         r_fail   <= 1'b0;
      end else begin
         r_state  <= w_nextState;
         r_cnt    <= w_nextCnt;
         r_retry  <= w_nextRetry;
         r_pllRst <= (w_nextState == S_RESET) || (w_nextState == S_FAIL);
         r_sysRst <= (w_nextState != S_RUN);
         r_ready  <= (w_nextState == S_RUN);
         r_fail   <= (w_nextState == S_FAIL);
      end
   end

`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
   logic       w_lossEvent;
   logic [7:0] r_lossCnt;

   assign w_lossEvent = (r_state == S_RUN) && !r_sync2;

   always_ff @(posedge refclk) begin
      if (rst) begin
         r_lossCnt <= 8'd0;
      end else if (w_lossEvent && (r_lossCnt != 8'hFF)) begin
         r_lossCnt <= r_lossCnt + 8'd1;
      end
   end

   assign lock_loss_cnt = r_lossCnt;
`endif

   assign pll_rst     = r_pllRst;
   assign sys_rst     = r_sysRst;
   assign ready       = r_ready;
   assign fail        = r_fail;
   assign retry_count = r_retry;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq with short timing parameters (pulse 4, stable 8, timeout 32, retries 2).
// Inputs are driven and outputs sampled 1 ns after each rising refclk edge.
module tb_pll_reset_seq;

   logic       refclk;
   logic       rst;
   logic       pll_locked;
   logic       pll_rst;
   logic       sys_rst;
   logic       ready;
   logic       fail;
   logic [1:0] retry_count;
`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
   logic [7:0] lock_loss_cnt;
`endif

   int testsRun  = 0;
   int testsFail = 0;

   pll_reset_seq #(
      .RST_PULSE_CYCLES   (4),
      .LOCK_STABLE_CYCLES (8),
      .LOCK_TIMEOUT_CYCLES(32),
      .MAX_RETRIES        (2),
      .CNT_W              (17)
   ) dut (
      .refclk       (refclk),
      .rst          (rst),
      .pll_locked   (pll_locked),
      .pll_rst      (pll_rst),
      .sys_rst      (sys_rst),
      .ready        (ready),
      .fail         (fail),
`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
      .lock_loss_cnt(lock_loss_cnt),
`endif
      .retry_count  (retry_count)
   );

   initial refclk = 1'b0;
   always #10 refclk = ~refclk;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      testsRun++;
      if (observed !== expected) begin
         testsFail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int cycles);
      repeat (cycles) @(posedge refclk);
      #1;
   endtask

   // Counts samples (current one included) while pll_rst stays at level, bounded
   task automatic countWhile(input logic level, output int n);
      n = 0;
      while ((pll_rst === level) && (n < 200)) begin
         n++;
         applyStimulus(1);
      end
   endtask

   // Counts edges until ready rises, bounded
   task automatic edgesToReady(output int n);
      n = 0;
      while ((ready !== 1'b1) && (n < 200)) begin
         applyStimulus(1);
         n++;
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_pll_rst"}, int'(pll_rst), 1);
      checkOutput({tag, "_sys_rst"}, int'(sys_rst), 1);
      checkOutput({tag, "_ready"}, int'(ready), 0);
      checkOutput({tag, "_fail"}, int'(fail), 0);
      checkOutput({tag, "_retry"}, int'(retry_count), 0);
   endtask

   int n;

   initial begin
      rst        = 1'b1;
      pll_locked = 1'b0;
      applyStimulus(3);
      checkResetState("reset");
`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
      checkOutput("reset_loss_cnt", int'(lock_loss_cnt), 0);
`endif

      // Nominal bring-up, lock raised 10 cycles after release
      rst = 1'b0;
      countWhile(1'b1, n);
      checkOutput("nom_pll_rst_len", n, 4);
      checkOutput("nom_sys_rst_wait", int'(sys_rst), 1);
      applyStimulus(6);
      pll_locked = 1'b1;
      edgesToReady(n);
      checkOutput("nom_edges_to_ready", n, 11);
      checkOutput("nom_sys_rst", int'(sys_rst), 0);
      checkOutput("nom_pll_rst", int'(pll_rst), 0);
      checkOutput("nom_retry", int'(retry_count), 0);
      checkOutput("nom_fail", int'(fail), 0);

      // One-cycle lock loss while running
      applyStimulus(3);
      pll_locked = 1'b0;
      applyStimulus(1);
      pll_locked = 1'b1;
      applyStimulus(1);
      checkOutput("loss_ready_held", int'(ready), 1);
      applyStimulus(1);
      checkOutput("loss_sys_rst", int'(sys_rst), 1);
      checkOutput("loss_ready", int'(ready), 0);
      countWhile(1'b1, n);
      checkOutput("loss_pll_rst_len", n, 4);
      checkOutput("loss_retry", int'(retry_count), 0);
`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
      checkOutput("loss_cnt", int'(lock_loss_cnt), 1);
`endif
      edgesToReady(n);
      checkOutput("loss_relock_edges", n, 9);

      // Glitch during STABLE: high 5, low 1, high
      rst        = 1'b1;
      pll_locked = 1'b0;
      applyStimulus(2);
      checkResetState("glitch_reset");
      rst = 1'b0;
      countWhile(1'b1, n);
      checkOutput("glitch_pll_rst_len", n, 4);
      pll_locked = 1'b1;
      applyStimulus(5);
      pll_locked = 1'b0;
      applyStimulus(1);
      pll_locked = 1'b1;
      checkOutput("glitch_sys_rst", int'(sys_rst), 1);
      edgesToReady(n);
      checkOutput("glitch_edges_to_ready", n, 11);
      checkOutput("glitch_retry", int'(retry_count), 0);

      // Repeated timeouts ending in FAIL
      rst        = 1'b1;
      pll_locked = 1'b0;
      applyStimulus(2);
      rst = 1'b0;
      countWhile(1'b1, n);
      checkOutput("to_pulse0", n, 4);
      countWhile(1'b0, n);
      checkOutput("to_window1", n, 32);
      checkOutput("to_retry1", int'(retry_count), 1);
      countWhile(1'b1, n);
      checkOutput("to_pulse1", n, 4);
      countWhile(1'b0, n);
      checkOutput("to_window2", n, 32);
      checkOutput("to_retry2", int'(retry_count), 2);
      countWhile(1'b1, n);
      checkOutput("to_pulse2", n, 4);
      countWhile(1'b0, n);
      checkOutput("to_window3", n, 32);
      checkOutput("fail_flag", int'(fail), 1);
      checkOutput("fail_pll_rst", int'(pll_rst), 1);
      checkOutput("fail_sys_rst", int'(sys_rst), 1);
      checkOutput("fail_retry", int'(retry_count), 2);
      pll_locked = 1'b1;
      applyStimulus(20);
      checkOutput("fail_sticky", int'(fail), 1);
      checkOutput("fail_sticky_pll_rst", int'(pll_rst), 1);
      checkOutput("fail_sticky_ready", int'(ready), 0);

      // Reset out of FAIL
      rst = 1'b1;
      applyStimulus(1);
      checkResetState("fail_rst");

      // One timeout, then lock lands on the last WAIT_LOCK cycle
      pll_locked = 1'b0;
      rst        = 1'b0;
      countWhile(1'b1, n);
      countWhile(1'b0, n);
      checkOutput("col_window1", n, 32);
      countWhile(1'b1, n);
      checkOutput("col_pulse", n, 4);
      applyStimulus(29);
      pll_locked = 1'b1;
      applyStimulus(3);
      checkOutput("col_pll_rst", int'(pll_rst), 0);
      checkOutput("col_retry", int'(retry_count), 1);
      edgesToReady(n);
      checkOutput("col_edges_to_ready", n, 8);
      checkOutput("col_retry_run", int'(retry_count), 0);

      // Reset in STABLE after a retry, then a full restart
      rst        = 1'b1;
      pll_locked = 1'b0;
      applyStimulus(2);
      rst = 1'b0;
      countWhile(1'b1, n);
      countWhile(1'b0, n);
      countWhile(1'b1, n);
      pll_locked = 1'b1;
      applyStimulus(6);
      checkOutput("stab_retry_pre", int'(retry_count), 1);
      rst = 1'b1;
      applyStimulus(1);
      checkResetState("stab_rst");
      rst = 1'b0;
      countWhile(1'b1, n);
      checkOutput("restart_pll_rst_len", n, 4);
      edgesToReady(n);
      checkOutput("restart_edges_to_ready", n, 9);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
      $finish;
   end

endmodule
